dbg_bus_arbiter: RTL
====================

Name: dbg_bus_arbiter

Overview:
- Shares the single data-memory port between the CPU core and the JTAG debug module's system-bus path (sbaddress0/sbdata0 accesses).
- Stalls the core through core_hold and waits a fixed drain window for in-flight core accesses to retire.
- Then performs one debug access per request and returns the port to the core, or keeps it while the debug module holds the hart halted.
- Sits between the core's load/store unit, the debug module and data RAM.

Parameters:
ADDR_W  32  address width of all three bus interfaces
DATA_W  32  data width of all three bus interfaces
DRAIN_CYCLES  2  cycles core_hold is asserted before the first debug access; legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core access request (level)
core_we  in  1  core write enable
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access accepted this cycle
core_hold  out  1  pipeline stall to core
dbg_req  in  1  single-cycle debug access request pulse
dbg_we  in  1  debug write enable, sampled with dbg_req
dbg_addr  in  ADDR_W  debug address, sampled with dbg_req
dbg_wdata  in  DATA_W  debug write data, sampled with dbg_req
dbg_halted  in  1  debug module holds hart halted (level)
dbg_busy  out  1  arbiter cannot accept dbg_req
dbg_done  out  1  one-cycle pulse: debug access complete
dbg_rdata  out  DATA_W  read data, valid while dbg_done=1 after a read
dbg_ovf  out  1  one-cycle pulse: dbg_req dropped
bus_req  out  1  memory access strobe
bus_we  out  1  memory write enable
bus_addr  out  ADDR_W  memory address
bus_wdata  out  DATA_W  memory write data
bus_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

Behaviour:
- Reset values: state CORE, pending flag 0, core_hold 0, dbg_busy 0, dbg_done 0, dbg_ovf 0, dbg_rdata 0, latched command 0. The bus_* and core_gnt outputs follow the CORE mux.
- States: CORE, DRAIN, DBG, RESP, HALT. core_hold = (state != CORE), decoded from the state register.
- Command latch: dbg_req with no pending command stores {we, addr, wdata} and sets the pending flag.
  - dbg_req while pending=1 is dropped and pulses dbg_ovf next cycle.
  - dbg_busy = pending | (state == DRAIN) | (state == DBG) | (state == RESP).
- CORE:
  - bus_* = core_*; core_gnt = core_req.
  - pending or dbg_req -> DRAIN, drain counter loaded with DRAIN_CYCLES.
  - dbg_halted=1 -> DRAIN.
  - The core access presented in the transition cycle is still granted.
- DRAIN:
  - bus_req=0, core_gnt=0; counter decrements each cycle.
  - When counter==1: pending -> DBG, else -> HALT (halt-only entry).
- DBG:
  - Exactly one cycle; bus_req=1, bus_we/addr/wdata from latch; pending clears; -> RESP.
- RESP:
  - bus_req=0. dbg_done=1 for this cycle.
  - If the latched op was a read, dbg_rdata <= bus_rdata, captured at entry so it is valid throughout RESP. After a write, dbg_rdata holds its old value.
  - Next state: pending -> DBG (no re-drain); else dbg_halted -> HALT; else -> CORE.
- HALT:
  - bus_req=0, core_hold=1.
  - pending or dbg_req -> DBG directly, without a drain.
  - dbg_halted=0 and no pending -> CORE.
- Latency, from dbg_req in CORE: DRAIN_CYCLES cycles of drain, then 1 DBG cycle, then dbg_done. dbg_done rises DRAIN_CYCLES+2 cycles after the dbg_req cycle. From HALT, dbg_done rises 2 cycles after dbg_req.
- Simultaneous events:
  - dbg_req and dbg_halted rising in the same cycle: the access is served first, then HALT.
  - dbg_halted falling while in DBG or RESP: the access completes, then CORE.
- Reset mid-operation: immediate return to CORE and the pending command is discarded. A DBG-cycle write may be lost; the debug module re-issues it after reset.
- No address arithmetic. Widths pass through unchanged.

Test Plan:
- Core-only traffic, dbg_req never asserted: core_req=1, we=1, addr 0x100, wdata 0xA5A5A5A5 -> bus mirrors core the same cycle; core_gnt=1; core_hold=0 throughout.
- dbg_req write (addr 0x2000, wdata 0xDEADBEEF), DRAIN_CYCLES=2, at cycle 0 in CORE -> core_hold high cycles 1-4; bus_req=1, we=1 at cycle 3 with those values; dbg_done=1 at cycle 4; core_hold=0 at cycle 5.
- Debug read of 0x2000 with memory returning 0xDEADBEEF -> dbg_done=1 and dbg_rdata=0xDEADBEEF in the same cycle; bus_we=0 during the DBG cycle.
- dbg_halted=1, then two reads spaced 3 cycles apart -> HALT entered after the drain; each read completes in 2 cycles with no re-drain; core_hold stays 1. dbg_halted=0 -> core_hold=0 next cycle.
- Second dbg_req while the first is pending -> dbg_ovf pulses once; only one bus access occurs; dbg_busy=1 from the cycle after the first dbg_req until RESP exits.
- rst_n asserted in the DBG cycle -> core_hold=0, dbg_busy=0, bus_req follows core_req immediately; no dbg_done pulse after reset release.

Source files
------------

// File: rtl/dbg_bus_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around dbg_bus_arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface dbg_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_hold;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_halted;
  logic              dbg_busy;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ovf;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_hold,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halted,
    output dbg_busy, dbg_done, dbg_rdata, dbg_ovf,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_hold,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halted,
    input  dbg_busy, dbg_done, dbg_rdata, dbg_ovf,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/dbg_bus_arbiter.sv
// Shares the data-memory port between the core LSU and the debug system bus.
// Core is stalled and drained before each debug access; port stays held while halted.
module dbg_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dbg_bus_arbiter_if.slave bus_if
);
  typedef enum logic [2:0] {
    S_CORE,
    S_DRAIN,
    S_DBG,
    S_RESP,
    S_HALT
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic              pend_q, pend_d;
  logic              hold_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [DATA_W-1:0] rdata_q;
  logic              take;

  assign take = bus_if.dbg_req & ~pend_q;

  // Next state, drain countdown and command latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    pend_d  = pend_q;
    if (take) begin
      cmd_d  = '{we: bus_if.dbg_we,
                 addr: bus_if.dbg_addr,
                 wdata: bus_if.dbg_wdata};
      pend_d = 1'b1;
    end
    unique case (state_q)
      S_CORE: begin
        if (pend_q | bus_if.dbg_req | bus_if.dbg_halted) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = pend_q ? S_DBG : S_HALT;
        end
      end
      S_DBG: begin
        pend_d  = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (pend_q) begin
          state_d = S_DBG;
        end else if (bus_if.dbg_halted) begin
          state_d = S_HALT;
        end else begin
          state_d = S_CORE;
        end
      end
      S_HALT: begin
        if (pend_q | bus_if.dbg_req) begin
          state_d = S_DBG;
        end else if (!bus_if.dbg_halted) begin
          state_d = S_CORE;
        end
      end
      default: state_d = S_CORE;
    endcase
  end

  // FSM state plus registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CORE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      pend_q  <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      hold_q  <= (state_d != S_CORE);
      busy_q  <= pend_d | (state_d == S_DRAIN) |
                 (state_d == S_DBG) | (state_d == S_RESP);
      done_q  <= (state_d == S_RESP);
      ovf_q   <= bus_if.dbg_req & pend_q;
      if ((state_q == S_RESP) && !cmd_q.we) begin
        rdata_q <= bus_if.bus_rdata;
      end
    end
  end

  // Port steering: core passes straight through in CORE, latch drives DBG.
  always_comb begin
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = cmd_q.addr;
    bus_if.bus_wdata = cmd_q.wdata;
    bus_if.core_gnt  = 1'b0;
    unique case (1'b1)
      (state_q == S_CORE): begin
        bus_if.bus_req   = bus_if.core_req;
        bus_if.bus_we    = bus_if.core_we;
        bus_if.bus_addr  = bus_if.core_addr;
        bus_if.bus_wdata = bus_if.core_wdata;
        bus_if.core_gnt  = bus_if.core_req;
      end
      (state_q == S_DBG): begin
        bus_if.bus_req = 1'b1;
        bus_if.bus_we  = cmd_q.we;
      end
      default: ;
    endcase
  end

  // Read data arrives during RESP; pass it through then, hold it afterwards.
  always_comb begin
    bus_if.dbg_rdata = rdata_q;
    if ((state_q == S_RESP) && !cmd_q.we) begin
      bus_if.dbg_rdata = bus_if.bus_rdata;
    end
  end

  assign bus_if.core_hold = hold_q;
  assign bus_if.dbg_busy  = busy_q;
  assign bus_if.dbg_done  = done_q;
  assign bus_if.dbg_ovf   = ovf_q;
endmodule
